// File: rtl/riscv_mmio_ctrl.sv
// MMIO peripheral block: status, UART RX/TX byte FIFOs and optional cycle/instret counters.
// Optional counters are built only when MMIO_COUNTERS_EN is defined; loads return data one cycle after re.
module riscv_mmio_ctrl #(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);

  // 32-byte window above BASE_ADDR, word-selected by offset bits [4:2]
  logic [31:0] off;
  logic        hit;
  logic [2:0]  word;
  assign off  = addr - BASE_ADDR;
  assign hit  = (off[31:5] == 27'd0);
  assign word = off[4:2];

  logic rd_status, rd_rx, wr_tx, wr_crst;
  assign rd_status = re && hit && (word == 3'd0);
  assign rd_rx     = re && hit && (word == 3'd1);
  assign wr_tx     = we && hit && (word == 3'd2);
  assign wr_crst   = we && hit && (word == 3'd6);

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wp, rx_rp;
  logic [RXW:0]   rx_cnt;
  logic rx_full, rx_empty, rx_push, rx_pop;
  assign rx_full  = (rx_cnt == RX_FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_push  = uart_rx_valid && !rx_full;
  assign rx_pop   = rd_rx && !rx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= uart_rx_data;
        rx_wp         <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + {{RXW{1'b0}}, rx_push} - {{RXW{1'b0}}, rx_pop};
    end
  end

  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wp, tx_rp;
  logic [TXW:0]   tx_cnt;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_ovf;
  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr_tx && !tx_full;
  assign tx_pop   = !tx_empty && uart_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= wdata[7:0];
        tx_wp         <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + {{TXW{1'b0}}, tx_push} - {{TXW{1'b0}}, tx_pop};
      // a dropped store wins over a same-cycle STATUS read clear
      if (wr_tx && tx_full) tx_ovf <= 1'b1;
      else if (rd_status)   tx_ovf <= 1'b0;
    end
  end

  logic [31:0] cycle_val, instret_val;
`ifdef MMIO_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;
  always_ff @(posedge clk) begin
    if (rst || wr_crst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      instret_q <= instret_q + {31'd0, inst_retire};
    end
  end
  assign cycle_val   = cycle_q;
  assign instret_val = instret_q;
  logic unused_bits;
  assign unused_bits = ^{off[1:0], wdata[31:8]};
`else
  assign cycle_val   = '0;
  assign instret_val = '0;
  logic unused_bits;
  assign unused_bits = ^{off[1:0], wdata[31:8], inst_retire, wr_crst};
`endif

  logic [31:0] status, rd_val, rdata_q;
  assign status = {16'd0, 8'(rx_cnt), 5'd0, tx_ovf, !rx_empty, !tx_full};

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (word)
        3'd0:    rd_val = status;
        3'd1:    rd_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
        3'd4:    rd_val = cycle_val;
        3'd5:    rd_val = instret_val;
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= re ? rd_val : 32'd0;
  end

  // outputs forced to their idle values for the whole time reset is held
  assign rdata         = rst ? 32'd0 : rdata_q;
  assign uart_rx_ready = rst | ~rx_full;
  assign uart_tx_valid = ~rst & ~tx_empty;
  assign uart_tx_data  = (rst || tx_empty) ? 8'h00 : tx_mem[tx_rp];
endmodule

// File: tb/tb_riscv_mmio_ctrl.sv
// Randomized and directed bench for riscv_mmio_ctrl against a queue-based reference model.
module tb_riscv_mmio_ctrl;
  localparam int          RXD  = 8;
  localparam int          TXD  = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, inst_retire;
  logic [7:0]  uart_rx_data, uart_tx_data;
  logic        uart_rx_valid, uart_rx_ready, uart_tx_valid, uart_tx_ready;

  riscv_mmio_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .inst_retire(inst_retire), .rdata(rdata),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          ovf;
  int unsigned mcyc, mins;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one rising edge, from the values visible before it
  task automatic model_edge();
    logic [31:0] o, rd;
    bit rx_pop, rx_push, tx_push, tx_pop, set_ovf;
    if (rst) begin
      rxq.delete(); txq.delete();
      ovf = 0; mcyc = 0; mins = 0; exp_rdata = 0;
      return;
    end
    o  = addr - BASE;
    if (o < 32) o = o & ~32'd3; else o = 32'hFFFF_FFFF;
    rd = 0;
    if (re) begin
      if (o == 0)
        rd = (rxq.size() << 8) | (ovf ? 4 : 0) | (rxq.size() > 0 ? 2 : 0) | (txq.size() < TXD ? 1 : 0);
      else if (o == 4)  rd = (rxq.size() > 0) ? 32'(rxq[0]) : 0;
`ifdef MMIO_COUNTERS_EN
      else if (o == 16) rd = mcyc;
      else if (o == 20) rd = mins;
`endif
    end
    rx_pop  = re && o == 4 && rxq.size() > 0;
    rx_push = uart_rx_valid && rxq.size() < RXD;
    tx_push = we && o == 8 && txq.size() < TXD;
    set_ovf = we && o == 8 && txq.size() == TXD;
    tx_pop  = txq.size() > 0 && uart_tx_ready;
    if (rx_pop)  void'(rxq.pop_front());
    if (rx_push) rxq.push_back(uart_rx_data);
    if (tx_pop)  void'(txq.pop_front());
    if (tx_push) txq.push_back(wdata[7:0]);
    if (set_ovf) ovf = 1;
    else if (re && o == 0) ovf = 0;
`ifdef MMIO_COUNTERS_EN
    if (we && o == 24) begin mcyc = 0; mins = 0; end
    else begin mcyc = mcyc + 1; mins = mins + (inst_retire ? 1 : 0); end
`endif
    exp_rdata = rd;
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      chk("rdata_in_rst", rdata, 0);
      chk("rx_ready_in_rst", 32'(uart_rx_ready), 1);
      chk("tx_valid_in_rst", 32'(uart_tx_valid), 0);
      chk("tx_data_in_rst", 32'(uart_tx_data), 0);
    end else begin
      chk("rdata", rdata, exp_rdata);
      chk("rx_ready", 32'(uart_rx_ready), 32'(rxq.size() < RXD));
      chk("tx_valid", 32'(uart_tx_valid), 32'(txq.size() > 0));
      chk("tx_data", 32'(uart_tx_data), txq.size() > 0 ? 32'(txq[0]) : 32'd0);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re = 0; we = 0; addr = BASE + 32'h40; wdata = 0;
    inst_retire = 0; uart_rx_valid = 0; uart_rx_data = 0;
  endtask

  task automatic rd_reg(input logic [31:0] a);
    idle(); re = 1; addr = a; step(); re = 0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    idle(); we = 1; addr = a; wdata = d; step(); we = 0;
  endtask

  logic [31:0] addr_tab [10];

  initial begin
    addr_tab = '{BASE, BASE+4, BASE+8, BASE+32'hC, BASE+32'h10, BASE+32'h14,
                 BASE+32'h18, BASE+32'h1C, BASE+32'h20, 32'h0000_0008};
    idle(); uart_tx_ready = 0; rst = 1;
    repeat (3) step();
    rst = 0;

    rd_reg(BASE);
    chk("status_after_reset", rdata, 32'h1);
    repeat (8) step();
    rd_reg(BASE + 32'h10);
`ifdef MMIO_COUNTERS_EN
    chk("cycle_10th", rdata, 32'd9);
`else
    chk("cycle_10th", rdata, 32'd0);
`endif

    // fill RX, then pop while a new byte is offered
    for (int i = 0; i < 8; i++) begin
      idle(); uart_rx_valid = 1; uart_rx_data = 8'(8'h41 + i); step();
    end
    idle();
    chk("rx_full_ready", 32'(uart_rx_ready), 0);
    rd_reg(BASE);
    chk("rx_occ_8", {24'd0, rdata[15:8]}, 32'd8);
    idle(); re = 1; addr = BASE + 4; uart_rx_valid = 1; uart_rx_data = 8'h99; step();
    idle();
    chk("pop_when_full", rdata, 32'h41);
    chk("ready_after_pop", 32'(uart_rx_ready), 1);
    rd_reg(BASE);
    chk("rx_occ_7", {24'd0, rdata[15:8]}, 32'd7);
    for (int i = 1; i < 8; i++) begin
      rd_reg(BASE + 4);
      chk("rx_order", rdata, 32'(8'h41 + i));
    end
    rd_reg(BASE + 4);
    chk("rx_empty_read", rdata, 0);

    // TX overflow with transmitter stalled
    uart_tx_ready = 0;
    for (int i = 0; i < 9; i++) wr_reg(BASE + 8, 32'h100 + 32'(8'h61 + i));
    rd_reg(BASE);
    chk("status_ovf", rdata, 32'h4);
    rd_reg(BASE);
    chk("status_ovf_clr", rdata, 32'h0);
    idle(); uart_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_order", 32'(uart_tx_data), 32'(8'h61 + i));
      step();
    end
    chk("tx_drained", 32'(uart_tx_valid), 0);

    // counter reset overrides increment
    idle(); we = 1; addr = BASE + 32'h18; inst_retire = 1; step();
    rd_reg(BASE + 32'h10);
    chk("cycle_cleared", rdata, 0);
    rd_reg(BASE + 32'h14);
    chk("instret_cleared", rdata, 0);

    // reset with both FIFOs populated
    uart_tx_ready = 0;
    for (int i = 0; i < 3; i++) wr_reg(BASE + 8, 32'(8'hA0 + i));
    for (int i = 0; i < 2; i++) begin
      idle(); uart_rx_valid = 1; uart_rx_data = 8'(8'hB0 + i); step();
    end
    idle(); rst = 1; step(); rst = 0;
    chk("tx_valid_post_rst", 32'(uart_tx_valid), 0);
    rd_reg(BASE);
    chk("status_post_rst", rdata, 32'h1);
    rd_reg(BASE + 4);
    chk("rx_stale", rdata, 0);

    // randomized traffic with varying backpressure
    for (int phase = 0; phase < 6; phase++) begin
      for (int n = 0; n < 500; n++) begin
        re            = ($urandom_range(0, 1) == 1);
        we            = ($urandom_range(0, 2) == 0);
        addr          = addr_tab[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
        wdata         = $urandom;
        inst_retire   = ($urandom_range(0, 1) == 1);
        uart_rx_valid = ($urandom_range(0, 3) < (phase % 3) + 1);
        uart_rx_data  = 8'($urandom);
        uart_tx_ready = ($urandom_range(0, 3) < phase / 2);
        rst           = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    rst = 0; idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
